key_debounce: RTL and testbench

Per-key synchronizer, debouncer and edge detector for the active-low board push-buttons. It sits between the raw `KEY` pins and the register/datapath logic that consumes them, such as the 5-bit parallel-load register's `load` input. It removes metastability and contact bounce, then presents three outputs per key:

- a clean active-high `pressed` level;
- a one-cycle `press_pulse`;
- a one-cycle `release_pulse`.

Consumers clocked from the divided clock use `pressed`. Consumers on the base clock use the pulses.

---
 rtl/key_debounce.sv | 126 ++++++++++++
 tb/tb_key_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer, bounce filter and press/release edge strobes
// for active-low push-buttons. Every key runs an independent, identical slice.
module key_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

    // Synchronizer resets to the released level so no spurious press follows reset.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pressed_q;
        logic             pressed_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pressed_q <= pressed_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // A reversal of s2 is tested before the terminal count, so it wins the race.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            pressed_d = pressed_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!s2[i]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s2[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TERM) begin
                        state_d   = PRESSED;
                        cnt_d     = '0;
                        pressed_d = 1'b1;
                        press_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (s2[i]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s2[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == TERM) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        pressed_d = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                end
            endcase
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed and random key activity, checked every cycle
// against a run-length reference model through an expected-value queue.
module tb_key_debounce;

    localparam int WIDTH  = 4;
    localparam int STABLE = 4;
    localparam int CNT_W  = 3;
    localparam int OW     = 3 * WIDTH;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] key_n;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    key_debounce #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [OW-1:0] exp_q[$];
    bit done = 1'b0;

    // ---------------- reference model ----------------
    // A key's accepted level flips once the synchronized input has disagreed
    // with it on STABLE+1 consecutive edges; any agreement clears the run.
    logic [WIDTH-1:0] hist[$];
    bit               acc[WIDTH];
    int               run[WIDTH];

    always @(posedge clk) begin
        logic [WIDTH-1:0] obs;
        logic [WIDTH-1:0] e_pr, e_pp, e_rp;
        e_pp = '0;
        e_rp = '0;
        if (reset) begin
            hist.delete();
            for (int k = 0; k < WIDTH; k++) begin
                acc[k] = 1'b0;
                run[k] = 0;
            end
        end else begin
            obs = (hist.size() >= 2) ? hist[hist.size()-2] : '1;
            hist.push_back(key_n);
            if (hist.size() > 2) void'(hist.pop_front());
            for (int k = 0; k < WIDTH; k++) begin
                if (bit'(!obs[k]) != acc[k]) begin
                    run[k]++;
                    if (run[k] == STABLE + 1) begin
                        acc[k] = !acc[k];
                        run[k] = 0;
                        if (acc[k]) e_pp[k] = 1'b1;
                        else        e_rp[k] = 1'b1;
                    end
                end else begin
                    run[k] = 0;
                end
            end
        end
        for (int k = 0; k < WIDTH; k++) e_pr[k] = acc[k];
        exp_q.push_back({e_pr, e_pp, e_rp});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [OW-1:0] exp_v;
        #1;
        if (!done) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
            end else begin
                exp_v = exp_q.pop_front();
                checks++;
                if ({pressed, press_pulse, release_pulse} === exp_v) passes++;
                else $display("FAIL cycle_out t=%0t: got pr=%b pp=%b rp=%b, need pr=%b pp=%b rp=%b",
                              $time, pressed, press_pulse, release_pulse,
                              exp_v[OW-1-:WIDTH], exp_v[2*WIDTH-1-:WIDTH], exp_v[WIDTH-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic [WIDTH-1:0] v, input int n);
        key_n = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_now(input string name);
        checks++;
        if (pressed === '0 && press_pulse === '0 && release_pulse === '0) passes++;
        else $display("FAIL %s: got pr=%b pp=%b rp=%b, need all zero",
                      name, pressed, press_pulse, release_pulse);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        key_n = 4'b0000;
        repeat (3) @(negedge clk);
        check_zero_now("reset_outputs");
        reset = 1'b0;
        hold(4'b0000, 12);                 // all four keys accepted together
        hold(4'b1111, 12);                 // all released

        hold(4'b1110, 20);                 // clean press on key 0
        hold(4'b1111, 12);

        // bounce on key 1 then a steady hold
        hold(4'b1101, 2); hold(4'b1111, 2);
        hold(4'b1101, 2); hold(4'b1111, 2);
        hold(4'b1101, 12);
        hold(4'b1111, 12);

        // key 2 low exactly STABLE samples: reversal lands on the terminal count
        hold(4'b1011, STABLE);
        hold(4'b1111, 10);

        // reset mid PRESS_WAIT on key 3, then press restarts from scratch
        hold(4'b0111, 5);
        #2 reset = 1'b1;
        #1 check_zero_now("reset_async_drop");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold(4'b0111, 12);
        hold(4'b1111, 12);

        // key 1 held, then press key 0 and release key 1 on the same edge
        hold(4'b1101, 12);
        hold(4'b1110, 12);
        hold(4'b1111, 12);

        // random activity, including reset pulses mid-operation
        for (int c = 0; c < 600; c++) begin
            logic [WIDTH-1:0] v;
            v = key_n;
            for (int k = 0; k < WIDTH; k++)
                if ($urandom_range(0, 5) == 0) v[k] = ~v[k];
            if ($urandom_range(0, 199) == 0) begin
                key_n = v;
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                hold(v, 1);
            end
        end
        hold(4'b1111, 12);

        @(posedge clk);
        #2 done = 1'b1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL queue_drain: got %0d pending entries, need 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, need finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
